// File: rtl/comparator_8bit_pkg.sv
// Shared constants for the cascadable magnitude comparator:
// result/cascade encoding and default operand width.
package comparator_8bit_pkg;

    localparam int unsigned DefaultWidth = 8;

    // Result vector layout {LT, EQ, GT}; exactly one bit set.
    localparam int unsigned IdxLt = 2;
    localparam int unsigned IdxEq = 1;
    localparam int unsigned IdxGt = 0;

    localparam logic [2:0] ResLt = 3'b100;
    localparam logic [2:0] ResEq = 3'b010;
    localparam logic [2:0] ResGt = 3'b001;

    localparam logic [2:0] ResReset = ResEq;

endpackage

// File: rtl/comparator_4bit.sv
// Combinational 4-bit cascadable magnitude slice: a local difference decides,
// equal nibbles pass the less-significant cascade through unchanged.
module comparator_4bit
    import comparator_8bit_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       lt_i,
    input  logic       eq_i,
    input  logic       gt_i,
    output logic       lt_o,
    output logic       eq_o,
    output logic       gt_o
);

    logic [2:0] res;

    always_comb begin
        res = {lt_i, eq_i, gt_i};
        if (a_i > b_i) begin
            res = ResGt;
        end else if (a_i < b_i) begin
            res = ResLt;
        end
    end

    assign lt_o = res[IdxLt];
    assign eq_o = res[IdxEq];
    assign gt_o = res[IdxGt];

endmodule

// File: rtl/comparator_8bit.sv
// Registered unsigned magnitude comparator built from a chain of 4-bit slices,
// LS nibble first; the incoming cascade is normalised to one-hot before use.
module comparator_8bit
    import comparator_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LTin,
    input  logic             EQin,
    input  logic             GTin,
    output logic             LTout,
    output logic             EQout,
    output logic             GTout,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B
);

    localparam int unsigned NumSlices = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("comparator_8bit: WIDTH must be a multiple of 4 and at least 4");
    end

    logic [NumSlices:0][2:0] casc;
    logic [2:0]              casc_in;
    logic [2:0]              res_d;
    logic [2:0]              res_q;

    // Invalid cascades (none set, or LT and GT together) collapse to EQ.
    always_comb begin
        casc_in = ResEq;
        if (EQin) begin
            casc_in = ResEq;
        end else if (GTin && !LTin) begin
            casc_in = ResGt;
        end else if (LTin && !GTin) begin
            casc_in = ResLt;
        end
    end

    assign casc[0] = casc_in;

    for (genvar i = 0; i < NumSlices; i++) begin : g_slice
        comparator_4bit u_slice (
            .a_i  (A[4*i +: 4]),
            .b_i  (B[4*i +: 4]),
            .lt_i (casc[i][IdxLt]),
            .eq_i (casc[i][IdxEq]),
            .gt_i (casc[i][IdxGt]),
            .lt_o (casc[i+1][IdxLt]),
            .eq_o (casc[i+1][IdxEq]),
            .gt_o (casc[i+1][IdxGt])
        );
    end

    always_comb begin
        res_d = casc[NumSlices];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= ResReset;
        end else begin
            res_q <= res_d;
        end
    end

    assign LTout = res_q[IdxLt];
    assign EQout = res_q[IdxEq];
    assign GTout = res_q[IdxGt];

endmodule

// File: tb/tb_comparator_8bit.sv
// Directed and random stimulus for comparator_8bit, checked every cycle
// against an arithmetic reference model plus hand-computed expectations.
module tb_comparator_8bit;

    localparam logic [2:0] ExpLt = 3'b100;
    localparam logic [2:0] ExpEq = 3'b010;
    localparam logic [2:0] ExpGt = 3'b001;

    logic       clk;
    logic       rst_n;
    logic       lt_in, eq_in, gt_in;
    logic       lt_out, eq_out, gt_out;
    logic [7:0] a_in, b_in;

    logic       lit_en;
    logic [2:0] lit_exp;
    string      lit_name;

    logic       lit_en_q;
    logic [2:0] lit_q;
    string      lit_name_q;
    logic [2:0] model_q;

    int n_vec;
    int n_err;

    comparator_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .LTin  (lt_in),
        .EQin  (eq_in),
        .GTin  (gt_in),
        .LTout (lt_out),
        .EQout (eq_out),
        .GTout (gt_out),
        .A     (a_in),
        .B     (b_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model(input int unsigned a, input int unsigned b,
                                         input logic lt, input logic eq, input logic gt);
        if (a > b) return ExpGt;
        if (a < b) return ExpLt;
        if (eq) return ExpEq;
        if (gt && !lt) return ExpGt;
        if (lt && !gt) return ExpLt;
        return ExpEq;
    endfunction

    // Reference: result of the inputs seen at the last edge, EQ while in reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q    <= ExpEq;
            lit_en_q   <= 1'b0;
            lit_q      <= ExpEq;
            lit_name_q <= "reset";
        end else begin
            model_q    <= model(a_in, b_in, lt_in, eq_in, gt_in);
            lit_en_q   <= lit_en;
            lit_q      <= lit_exp;
            lit_name_q <= lit_name;
        end
    end

    always begin
        @(negedge clk or negedge rst_n);
        #1;
        n_vec++;
        if ({lt_out, eq_out, gt_out} !== model_q) begin
            n_err++;
            $display("FAIL model t=%0t A=%02h B=%02h got LT/EQ/GT=%b required %b",
                     $time, a_in, b_in, {lt_out, eq_out, gt_out}, model_q);
        end
        n_vec++;
        if (!$onehot({lt_out, eq_out, gt_out})) begin
            n_err++;
            $display("FAIL onehot t=%0t got LT/EQ/GT=%b required exactly one bit set",
                     $time, {lt_out, eq_out, gt_out});
        end
        if (!rst_n) begin
            n_vec++;
            if ({lt_out, eq_out, gt_out} !== ExpEq) begin
                n_err++;
                $display("FAIL reset t=%0t got LT/EQ/GT=%b required 010",
                         $time, {lt_out, eq_out, gt_out});
            end
        end else if (lit_en_q) begin
            n_vec++;
            if ({lt_out, eq_out, gt_out} !== lit_q) begin
                n_err++;
                $display("FAIL %s t=%0t got LT/EQ/GT=%b required %b",
                         lit_name_q, $time, {lt_out, eq_out, gt_out}, lit_q);
            end
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic lt,
                         input logic eq, input logic gt, input logic en,
                         input logic [2:0] exp, input string name);
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        lt_in    = lt;
        eq_in    = eq;
        gt_in    = gt;
        lit_en   = en;
        lit_exp  = exp;
        lit_name = name;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        a_in     = 8'hFF;
        b_in     = 8'h00;
        lt_in    = 1'b0;
        eq_in    = 1'b0;
        gt_in    = 1'b0;
        lit_en   = 1'b0;
        lit_exp  = ExpEq;
        lit_name = "idle";

        // Async reset between edges with GT-forcing operands present.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // First edge after release registers the live inputs (FF > 00).
        drive(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ExpEq, "idle");

        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, ExpEq, "eq_00");
        drive(8'hC0, 8'hC0, 1'b0, 1'b1, 1'b0, 1'b1, ExpEq, "eq_c0");

        drive(8'h40, 8'hC0, 1'b0, 1'b1, 1'b0, 1'b1, ExpLt, "seq_40_c0");
        drive(8'hF0, 8'hC0, 1'b0, 1'b1, 1'b0, 1'b1, ExpGt, "seq_f0_c0");
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, ExpEq, "seq_00_00");
        drive(8'hF0, 8'h70, 1'b0, 1'b1, 1'b0, 1'b1, ExpGt, "seq_f0_70");
        drive(8'h50, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, ExpLt, "seq_50_80");

        drive(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, ExpGt, "casc_gt");
        drive(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, ExpLt, "casc_lt");
        drive(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, ExpEq, "casc_none");
        drive(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, ExpEq, "casc_both");
        drive(8'h5A, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, ExpEq, "casc_eq_prio");

        drive(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, ExpGt, "ovr_ff_00");
        drive(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, ExpLt, "ovr_00_ff");
        drive(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, ExpEq, "ext_ff_ff");
        drive(8'h0F, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, ExpLt, "nibble_carry");

        // Mid-operation reset: pending GT must be dropped.
        drive(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ExpEq, "idle");
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, ExpEq, "idle");
        drive(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, ExpLt, "post_reset_lt");

        for (int i = 0; i < 1100; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = (($urandom_range(0, 3)) == 0) ? ra : 8'($urandom_range(0, 255));
            drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, ExpEq, "random");
        end

        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, ExpEq, "idle");
        repeat (2) @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
